pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/hazard_detect.sv | 15 +
 rtl/pipe_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control slice.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        VECTOR = 2'd2
    } state_t;

    localparam logic [3:0] REG_NONE     = 4'hF;
    localparam int         DRAIN_CYCLES = 2;
    // The accept cycle is the first flush cycle, so DRAIN covers the rest.
    localparam logic [1:0] DRAIN_LOAD   = 2'(DRAIN_CYCLES - 1);

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic flush_if;
        logic flush_id;
        logic pc_vec_sel;
        logic epc_capture;
        logic int_ack;
    } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the EX load and the ID sources.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       ex_memread_i,
    input  logic [3:0] ex_regdst_i,
    input  logic [3:0] id_rs1_i,
    input  logic [3:0] id_rs2_i,
    output logic       load_use
);

    assign load_use = ex_memread_i && (ex_regdst_i != REG_NONE) &&
                      ((ex_regdst_i == id_rs1_i) || (ex_regdst_i == id_rs2_i));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush control with a non-interruptible interrupt entry sequence.
module pipe_ctrl
    import pipe_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       ex_memread_i,
    input  logic [3:0] ex_regdst_i,
    input  logic [3:0] id_rs1_i,
    input  logic [3:0] id_rs2_i,
    input  logic       branch_taken_i,
    input  logic       mem_imem_req_i,
    input  logic       int_req_i,
    input  logic       int_en_i,
    output logic       pc_write_o,
    output logic       if_id_write_o,
    output logic       flush_if_o,
    output logic       flush_id_o,
    output logic       pc_vec_sel_o,
    output logic       epc_capture_o,
    output logic       int_ack_o
);

    state_t     state, state_nx;
    logic [1:0] cnt, cnt_nx;
    logic       pend, pend_nx;
    logic       load_use;
    logic       accept;
    ctrl_t      ctrl;

    hazard_detect u_hazard (
        .ex_memread_i (ex_memread_i),
        .ex_regdst_i  (ex_regdst_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .load_use     (load_use)
    );

    assign accept = (state == RUN) && pend && int_en_i && !load_use &&
                    !branch_taken_i && !mem_imem_req_i;

    // A new request in the acknowledge cycle stays pending.
    assign pend_nx = int_req_i | (pend & ~ctrl.int_ack);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= RUN;
            cnt   <= 2'd0;
            pend  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pend  <= pend_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            RUN: begin
                if (accept) begin
                    state_nx = DRAIN;
                    cnt_nx   = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                // Leave on the cycle the decrement brings the count to zero.
                cnt_nx = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
                if (cnt <= 2'd1)
                    state_nx = VECTOR;
            end
            VECTOR:  state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        ctrl = '0;
        if (!RST) begin
            ctrl.flush_if = 1'b1;
            ctrl.flush_id = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        ctrl.flush_id = 1'b1;
                    end else if (branch_taken_i) begin
                        ctrl.pc_write    = 1'b1;
                        ctrl.if_id_write = 1'b1;
                        ctrl.flush_if    = 1'b1;
                    end else if (mem_imem_req_i) begin
                        ctrl.if_id_write = 1'b1;
                        ctrl.flush_if    = 1'b1;
                    end else if (accept) begin
                        ctrl.epc_capture = 1'b1;
                        ctrl.flush_if    = 1'b1;
                        ctrl.flush_id    = 1'b1;
                    end else begin
                        ctrl.pc_write    = 1'b1;
                        ctrl.if_id_write = 1'b1;
                    end
                end
                DRAIN: begin
                    ctrl.flush_if = 1'b1;
                    ctrl.flush_id = 1'b1;
                end
                VECTOR: begin
                    ctrl.pc_vec_sel = 1'b1;
                    ctrl.pc_write   = 1'b1;
                    ctrl.int_ack    = 1'b1;
                    ctrl.flush_if   = 1'b1;
                end
                default: begin
                    ctrl.flush_if = 1'b1;
                    ctrl.flush_id = 1'b1;
                end
            endcase
        end
    end

    assign pc_write_o    = ctrl.pc_write;
    assign if_id_write_o = ctrl.if_id_write;
    assign flush_if_o    = ctrl.flush_if;
    assign flush_id_o    = ctrl.flush_id;
    assign pc_vec_sel_o  = ctrl.pc_vec_sel;
    assign epc_capture_o = ctrl.epc_capture;
    assign int_ack_o     = ctrl.int_ack;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes model outputs, negedge monitor compares.
module tb_pipe_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       ex_memread_i = 1'b0;
    logic [3:0] ex_regdst_i = 4'hF;
    logic [3:0] id_rs1_i = 4'h0;
    logic [3:0] id_rs2_i = 4'h0;
    logic       branch_taken_i = 1'b0;
    logic       mem_imem_req_i = 1'b0;
    logic       int_req_i = 1'b0;
    logic       int_en_i = 1'b0;
    logic       pc_write_o, if_id_write_o, flush_if_o, flush_id_o;
    logic       pc_vec_sel_o, epc_capture_o, int_ack_o;

    pipe_ctrl dut (
        .CLK            (CLK),
        .RST            (RST),
        .ex_memread_i   (ex_memread_i),
        .ex_regdst_i    (ex_regdst_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .branch_taken_i (branch_taken_i),
        .mem_imem_req_i (mem_imem_req_i),
        .int_req_i      (int_req_i),
        .int_en_i       (int_en_i),
        .pc_write_o     (pc_write_o),
        .if_id_write_o  (if_id_write_o),
        .flush_if_o     (flush_if_o),
        .flush_id_o     (flush_id_o),
        .pc_vec_sel_o   (pc_vec_sel_o),
        .epc_capture_o  (epc_capture_o),
        .int_ack_o      (int_ack_o)
    );

    always #5 CLK = ~CLK;

    // Bit order: {pc_write, if_id_write, flush_if, flush_id, vec_sel, epc, ack}
    localparam logic [6:0] E_RESET  = 7'b0011000;
    localparam logic [6:0] E_RUN    = 7'b1100000;
    localparam logic [6:0] E_STALL  = 7'b0001000;
    localparam logic [6:0] E_BRANCH = 7'b1110000;
    localparam logic [6:0] E_IMEM   = 7'b0110000;
    localparam logic [6:0] E_ACCEPT = 7'b0011010;
    localparam logic [6:0] E_VECTOR = 7'b1010101;

    logic [6:0] exp_q[$];
    string      tag_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    // Reference model: pending flag plus how many cycles into the entry sequence we are.
    bit m_pend  = 1'b0;
    int m_phase = 0;

    task automatic apply(input bit rst, input bit mr, input logic [3:0] rd,
                         input logic [3:0] r1, input logic [3:0] r2, input bit br,
                         input bit imem, input bit req, input bit en, input string tag);
        logic [6:0] e;
        bit hz;
        @(posedge CLK);
        #1;
        RST = rst; ex_memread_i = mr; ex_regdst_i = rd; id_rs1_i = r1; id_rs2_i = r2;
        branch_taken_i = br; mem_imem_req_i = imem; int_req_i = req; int_en_i = en;
        hz = mr && (rd != 4'hF) && (rd == r1 || rd == r2);
        if (!rst) begin
            e = E_RESET;
            m_pend = 1'b0;
            m_phase = 0;
        end else if (m_phase == 1) begin
            e = E_RESET;
            m_pend = req | m_pend;
            m_phase = 2;
        end else if (m_phase == 2) begin
            e = E_VECTOR;
            m_pend = req;
            m_phase = 0;
        end else begin
            if (hz)                 e = E_STALL;
            else if (br)            e = E_BRANCH;
            else if (imem)          e = E_IMEM;
            else if (m_pend && en) begin
                e = E_ACCEPT;
                m_phase = 1;
            end else                e = E_RUN;
            m_pend = req | m_pend;
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic idle(input int n, input bit en, input string tag);
        for (int i = 0; i < n; i++)
            apply(1, 0, 4'hF, 4'h0, 4'h0, 0, 0, 0, en, tag);
    endtask

    always @(negedge CLK) begin
        logic [6:0] e, got;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            got = {pc_write_o, if_id_write_o, flush_if_o, flush_id_o,
                   pc_vec_sel_o, epc_capture_o, int_ack_o};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL %s: outputs got %b expected %b at %0t", t, got, e, $time);
            end
        end
    end

    initial begin
        apply(0, 0, 4'hF, 0, 0, 0, 0, 0, 0, "reset");
        apply(0, 0, 4'hF, 0, 0, 0, 0, 1, 1, "reset_req");
        idle(2, 1, "idle");
        apply(1, 1, 4'd3, 4'd0, 4'd3, 0, 0, 0, 1, "load_use");
        idle(1, 1, "after_load_use");
        apply(1, 1, 4'hF, 4'hF, 4'd1, 0, 0, 0, 1, "no_dest_load");
        apply(1, 1, 4'd2, 4'd2, 4'd5, 0, 0, 0, 1, "load_use_rs1");
        apply(1, 0, 4'hF, 0, 0, 1, 0, 0, 1, "branch");
        apply(1, 0, 4'hF, 0, 0, 0, 1, 0, 1, "imem");
        apply(1, 1, 4'd4, 4'd4, 4'd0, 0, 1, 0, 1, "load_use_imem");
        apply(1, 0, 4'hF, 0, 0, 1, 1, 0, 1, "branch_imem");
        apply(1, 1, 4'd4, 4'd4, 4'd0, 1, 0, 0, 1, "load_use_branch");
        apply(1, 0, 4'hF, 0, 0, 0, 0, 1, 1, "int_pulse");
        idle(4, 1, "int_seq");
        apply(1, 1, 4'd5, 4'd5, 4'd0, 0, 0, 1, 1, "int_during_hazard");
        apply(1, 1, 4'd5, 4'd0, 4'd5, 0, 0, 0, 1, "hazard_hold");
        apply(1, 0, 4'hF, 0, 0, 1, 0, 0, 1, "branch_blocks");
        apply(1, 0, 4'hF, 0, 0, 0, 1, 0, 1, "imem_blocks");
        idle(4, 1, "int_released");
        apply(1, 0, 4'hF, 0, 0, 0, 0, 1, 0, "int_masked");
        idle(3, 0, "masked_hold");
        idle(4, 1, "unmasked");
        apply(1, 0, 4'hF, 0, 0, 0, 0, 1, 1, "int_for_reset");
        idle(1, 1, "accept_before_reset");
        apply(0, 0, 4'hF, 0, 0, 0, 0, 0, 1, "reset_in_drain");
        apply(0, 0, 4'hF, 0, 0, 0, 0, 0, 1, "reset_hold");
        idle(4, 1, "after_reset");
        apply(1, 0, 4'hF, 0, 0, 0, 0, 1, 1, "req_in_vector_a");
        idle(2, 1, "req_in_vector_b");
        apply(1, 0, 4'hF, 0, 0, 0, 0, 1, 1, "req_in_vector");
        idle(5, 1, "second_int");
        for (int i = 0; i < 400; i++) begin
            logic [3:0] rd, r1, r2;
            rd = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
            r1 = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
            r2 = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
            apply($urandom_range(0, 59) != 0, $urandom_range(0, 2) == 0, rd, r1, r2,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 4) != 0, "random");
        end
        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
